// File: rtl/dest_reg_pkg.sv
// Shared constants and helpers for the dest_reg_ring destination-register selector.
package dest_reg_pkg;

  localparam int   MAX_NREGS = 16;
  localparam logic DIR_FWD   = 1'b0;
  localparam logic DIR_REV   = 1'b1;

  // Index width for n registers; a 2-register ring still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dest_reg_next.sv
// Combinational next-index and wrap-flag for one advance of the ring.
// With DEST_REG_SKIP_EN defined, the advance searches past masked indices.
module dest_reg_next
  import dest_reg_pkg::*;
#(
  parameter  int NREGS = 3,
  localparam int IDX_W = idx_width(NREGS)
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_dir,
`ifdef DEST_REG_SKIP_EN
  input  logic [NREGS-1:0] i_skip,
`endif
  output logic [IDX_W-1:0] o_idx,
  output logic             o_wrap
);

`ifdef DEST_REG_SKIP_EN
  always_comb begin
    int               cand;
    logic             crossed;
    logic             found;
    logic [NREGS-1:0] w_shift;
    // NOTE: every variable gets a default before any branch, otherwise
    // synthesis infers a latch to hold it on the untaken paths.
    o_idx   = i_idx;
    o_wrap  = 1'b0;
    cand    = 0;
    crossed = 1'b0;
    found   = 1'b0;
    w_shift = '0;
    // The current index is never a candidate, so its own SKIP bit is ignored.
    for (int k = 1; k < NREGS; k++) begin
      cand    = (i_dir == DIR_FWD) ? int'(i_idx) + k : int'(i_idx) - k;
      crossed = (cand >= NREGS) || (cand < 0);
      if (cand >= NREGS) begin
        cand = cand - NREGS;
      end else if (cand < 0) begin
        cand = cand + NREGS;
      end
      w_shift = i_skip >> cand;
      if (!found && !w_shift[0]) begin
        found  = 1'b1;
        o_idx  = IDX_W'(cand);
        o_wrap = crossed;
      end
    end
  end
`else
  always_comb begin
    o_idx  = i_idx;
    o_wrap = 1'b0;
    unique case (i_dir)
      DIR_FWD: begin
        if (i_idx == IDX_W'(NREGS - 1)) begin
          o_idx  = '0;
          o_wrap = 1'b1;
        end else begin
          o_idx = i_idx + 1'b1;
        end
      end
      DIR_REV: begin
        if (i_idx == '0) begin
          o_idx  = IDX_W'(NREGS - 1);
          o_wrap = 1'b1;
        end else begin
          o_idx = i_idx - 1'b1;
        end
      end
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/dest_reg_ring.sv
// One-hot destination-register pointer: advance, reverse, direct load.
// Optional DEST_REG_SKIP_EN adds a SKIP mask honoured by advances.
module dest_reg_ring
  import dest_reg_pkg::*;
#(
  parameter  int NREGS = 3,
  parameter  int START = NREGS - 1,
  localparam int IDX_W = idx_width(NREGS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LDD,
  input  logic             DIR,
  input  logic             SET,
  input  logic [IDX_W-1:0] SET_IDX,
`ifdef DEST_REG_SKIP_EN
  input  logic [NREGS-1:0] SKIP,
`endif
  output logic [NREGS-1:0] SEL,
  output logic [IDX_W-1:0] IDX,
  output logic             WRAP,
  output logic             BAD_IDX
);

  if (NREGS < 2 || NREGS > MAX_NREGS || START < 0 || START >= NREGS) begin : g_bad_param
    $error("dest_reg_ring: NREGS or START out of range");
  end

  localparam logic [NREGS-1:0] SEL_RST = NREGS'(1) << START;

  logic [IDX_W-1:0] r_idx;
  logic [NREGS-1:0] r_sel;
  logic             r_wrap;
  logic             r_bad;

  logic [IDX_W-1:0] w_step_idx;
  logic             w_step_wrap;
  logic [IDX_W-1:0] w_idx_d;
  logic [NREGS-1:0] w_sel_d;
  logic             w_wrap_d;
  logic             w_bad_d;
  logic             w_set_ok;

  dest_reg_next #(
    .NREGS (NREGS)
  ) u_next (
    .i_idx  (r_idx),
    .i_dir  (DIR),
`ifdef DEST_REG_SKIP_EN
    .i_skip (SKIP),
`endif
    .o_idx  (w_step_idx),
    .o_wrap (w_step_wrap)
  );

  assign w_set_ok = int'(SET_IDX) < NREGS;

  // SET beats LDD; a rejected SET still swallows the advance.
  always_comb begin
    w_idx_d  = r_idx;
    w_wrap_d = 1'b0;
    w_bad_d  = 1'b0;
    if (SET) begin
      if (w_set_ok) begin
        w_idx_d = SET_IDX;
      end else begin
        w_bad_d = 1'b1;
      end
    end else if (LDD) begin
      w_idx_d  = w_step_idx;
      w_wrap_d = w_step_wrap;
    end
  end

  // SEL is decoded from the next index so it is registered alongside IDX.
  always_comb begin
    w_sel_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_sel_d[i] = (w_idx_d == IDX_W'(i));
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      r_idx  <= IDX_W'(START);
      r_sel  <= SEL_RST;
      r_wrap <= 1'b0;
      r_bad  <= 1'b0;
    end else begin
      r_idx  <= w_idx_d;
      r_sel  <= w_sel_d;
      r_wrap <= w_wrap_d;
      r_bad  <= w_bad_d;
    end
  end

  assign SEL     = r_sel;
  assign IDX     = r_idx;
  assign WRAP    = r_wrap;
  assign BAD_IDX = r_bad;

endmodule

// File: tb/tb_dest_reg_ring.sv
// Self-checking bench for dest_reg_ring: directed vector table over several
// ring sizes sharing one stimulus bus, then a random run against a small model.
module tb_dest_reg_ring;

  logic       clk = 1'b0;
  logic       rst, ldd, dir, set;
  logic [4:0] set_idx;
`ifdef DEST_REG_SKIP_EN
  logic [3:0] skip4;
`endif

  logic [1:0]  sel2;  logic [0:0] idx2;  logic wrap2,  bad2;
  logic [2:0]  sel3;  logic [1:0] idx3;  logic wrap3,  bad3;
  logic [3:0]  sel4;  logic [1:0] idx4;  logic wrap4,  bad4;
  logic [4:0]  sel5;  logic [2:0] idx5;  logic wrap5,  bad5;
  logic [6:0]  sel7;  logic [2:0] idx7;  logic wrap7,  bad7;
  logic [15:0] sel16; logic [3:0] idx16; logic wrap16, bad16;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dest_reg_ring #(.NREGS(2)) u2 (
    .CLK(clk), .RST(rst), .LDD(ldd), .DIR(dir), .SET(set), .SET_IDX(set_idx[0:0]),
`ifdef DEST_REG_SKIP_EN
    .SKIP('0),
`endif
    .SEL(sel2), .IDX(idx2), .WRAP(wrap2), .BAD_IDX(bad2));

  dest_reg_ring #(.NREGS(3)) u3 (
    .CLK(clk), .RST(rst), .LDD(ldd), .DIR(dir), .SET(set), .SET_IDX(set_idx[1:0]),
`ifdef DEST_REG_SKIP_EN
    .SKIP('0),
`endif
    .SEL(sel3), .IDX(idx3), .WRAP(wrap3), .BAD_IDX(bad3));

  dest_reg_ring #(.NREGS(4)) u4 (
    .CLK(clk), .RST(rst), .LDD(ldd), .DIR(dir), .SET(set), .SET_IDX(set_idx[1:0]),
`ifdef DEST_REG_SKIP_EN
    .SKIP(skip4),
`endif
    .SEL(sel4), .IDX(idx4), .WRAP(wrap4), .BAD_IDX(bad4));

  dest_reg_ring #(.NREGS(5)) u5 (
    .CLK(clk), .RST(rst), .LDD(ldd), .DIR(dir), .SET(set), .SET_IDX(set_idx[2:0]),
`ifdef DEST_REG_SKIP_EN
    .SKIP('0),
`endif
    .SEL(sel5), .IDX(idx5), .WRAP(wrap5), .BAD_IDX(bad5));

  dest_reg_ring #(.NREGS(7)) u7 (
    .CLK(clk), .RST(rst), .LDD(ldd), .DIR(dir), .SET(set), .SET_IDX(set_idx[2:0]),
`ifdef DEST_REG_SKIP_EN
    .SKIP('0),
`endif
    .SEL(sel7), .IDX(idx7), .WRAP(wrap7), .BAD_IDX(bad7));

  dest_reg_ring #(.NREGS(16)) u16 (
    .CLK(clk), .RST(rst), .LDD(ldd), .DIR(dir), .SET(set), .SET_IDX(set_idx[3:0]),
`ifdef DEST_REG_SKIP_EN
    .SKIP('0),
`endif
    .SEL(sel16), .IDX(idx16), .WRAP(wrap16), .BAD_IDX(bad16));

  typedef struct {
    int          n;
    logic        rst, ldd, dir, set;
    logic [4:0]  sidx;
    logic [3:0]  skip;
    logic [15:0] e_idx;
    logic        e_wrap, e_bad;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic r, input logic l, input logic d, input logic s,
                     input int sidx, input int e_idx, input logic e_wrap, input logic e_bad,
                     input logic [3:0] skip = 4'b0000);
    vec_t v;
    v.n = n; v.rst = r; v.ldd = l; v.dir = d; v.set = s;
    v.sidx = 5'(sidx); v.skip = skip;
    v.e_idx = 16'(e_idx); v.e_wrap = e_wrap; v.e_bad = e_bad;
    vecs.push_back(v);
  endtask

  task automatic read_dut(input int n, output logic [15:0] s, output logic [15:0] ix,
                          output logic w, output logic b);
    s = '0; ix = '0; w = 1'b0; b = 1'b0;
    case (n)
      2:  begin s = 16'(sel2);  ix = 16'(idx2);  w = wrap2;  b = bad2;  end
      3:  begin s = 16'(sel3);  ix = 16'(idx3);  w = wrap3;  b = bad3;  end
      4:  begin s = 16'(sel4);  ix = 16'(idx4);  w = wrap4;  b = bad4;  end
      5:  begin s = 16'(sel5);  ix = 16'(idx5);  w = wrap5;  b = bad5;  end
      7:  begin s = 16'(sel7);  ix = 16'(idx7);  w = wrap7;  b = bad7;  end
      16: begin s = sel16;      ix = 16'(idx16); w = wrap16; b = bad16; end
      default: ;
    endcase
  endtask

  initial begin
    logic [15:0] s, ix;
    logic        w, b;
    int          ns[6];
    int          m_idx[6];
    logic        m_wrap[6], m_bad[6];

    rst = 1'b0; ldd = 1'b0; dir = 1'b0; set = 1'b0; set_idx = '0;
`ifdef DEST_REG_SKIP_EN
    skip4 = '0;
`endif

    //   n  rst ldd dir set sidx  idx wrap bad
    // NREGS=3 forward ring, hold, out-of-range SET
    add(3, 1, 0, 0, 0, 0,   2, 0, 0);
    add(3, 0, 1, 0, 0, 0,   0, 1, 0);
    add(3, 0, 1, 0, 0, 0,   1, 0, 0);
    add(3, 0, 1, 0, 0, 0,   2, 0, 0);
    add(3, 0, 1, 0, 0, 0,   0, 1, 0);
    add(3, 0, 0, 1, 0, 0,   0, 0, 0);
    add(3, 0, 1, 0, 1, 3,   0, 0, 1);
    // NREGS=5 reverse ring
    add(5, 1, 0, 1, 0, 0,   4, 0, 0);
    add(5, 0, 1, 1, 0, 0,   3, 0, 0);
    add(5, 0, 1, 1, 0, 0,   2, 0, 0);
    add(5, 0, 1, 1, 0, 0,   1, 0, 0);
    add(5, 0, 1, 1, 0, 0,   0, 0, 0);
    add(5, 0, 1, 1, 0, 0,   4, 1, 0);
    add(5, 0, 1, 1, 0, 0,   3, 0, 0);
    // NREGS=5 SET priority and BAD_IDX
    add(5, 1, 0, 0, 0, 0,   4, 0, 0);
    add(5, 0, 1, 0, 1, 2,   2, 0, 0);
    add(5, 0, 1, 0, 1, 6,   2, 0, 1);
    add(5, 0, 0, 0, 0, 0,   2, 0, 0);
    add(5, 0, 1, 0, 1, 5,   2, 0, 1);
    add(5, 0, 0, 0, 1, 4,   4, 0, 0);
    add(5, 0, 1, 0, 0, 0,   0, 1, 0);
    add(5, 0, 1, 1, 1, 0,   0, 0, 0);
    // NREGS=4 reset mid-stream overrides LDD and SET
    add(4, 1, 0, 0, 0, 0,   3, 0, 0);
    add(4, 0, 1, 0, 0, 0,   0, 1, 0);
    add(4, 0, 1, 0, 0, 0,   1, 0, 0);
    add(4, 0, 1, 0, 0, 0,   2, 0, 0);
    add(4, 1, 1, 0, 0, 0,   3, 0, 0);
    add(4, 1, 0, 0, 1, 1,   3, 0, 0);
    // NREGS=2 both wrap directions
    add(2, 1, 0, 0, 0, 0,   1, 0, 0);
    add(2, 0, 1, 0, 0, 0,   0, 1, 0);
    add(2, 0, 1, 1, 0, 0,   1, 1, 0);
    add(2, 0, 1, 1, 0, 0,   0, 0, 0);
    // NREGS=16 full-width index
    add(16, 1, 0, 0, 0, 0,  15, 0, 0);
    add(16, 0, 1, 0, 0, 0,   0, 1, 0);
    add(16, 0, 0, 0, 1, 15, 15, 0, 0);
    add(16, 0, 1, 1, 0, 0,  14, 0, 0);
    // NREGS=7 non-power-of-two bound
    add(7, 1, 0, 0, 0, 0,   6, 0, 0);
    add(7, 0, 0, 0, 1, 7,   6, 0, 1);
    add(7, 0, 1, 0, 0, 0,   0, 1, 0);
`ifdef DEST_REG_SKIP_EN
    // NREGS=4 skip search: masked neighbours, fully masked ring, stale mask on current
    add(4, 1, 0, 0, 0, 0,   3, 0, 0, 4'b0000);
    add(4, 0, 0, 0, 1, 0,   0, 0, 0, 4'b0000);
    add(4, 0, 1, 0, 0, 0,   3, 0, 0, 4'b0110);
    add(4, 0, 1, 0, 0, 0,   0, 1, 0, 4'b0110);
    add(4, 0, 1, 0, 0, 0,   0, 0, 0, 4'b1110);
    add(4, 0, 1, 1, 0, 0,   3, 1, 0, 4'b0110);
    add(4, 0, 0, 0, 0, 0,   3, 0, 0, 4'b1000);
    add(4, 0, 1, 0, 0, 0,   0, 1, 0, 4'b1000);
    add(4, 0, 0, 0, 1, 1,   1, 0, 0, 4'b0010);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; ldd = vecs[i].ldd; dir = vecs[i].dir;
      set = vecs[i].set; set_idx = vecs[i].sidx;
`ifdef DEST_REG_SKIP_EN
      skip4 = vecs[i].skip;
`endif
      @(posedge clk); #1;
      read_dut(vecs[i].n, s, ix, w, b);
      check($sformatf("v%0d_n%0d_idx", i, vecs[i].n), ix, vecs[i].e_idx);
      check($sformatf("v%0d_n%0d_sel", i, vecs[i].n), s, 16'h0001 << vecs[i].e_idx);
      check($sformatf("v%0d_n%0d_wrap", i, vecs[i].n), 16'(w), 16'(vecs[i].e_wrap));
      check($sformatf("v%0d_n%0d_bad", i, vecs[i].n), 16'(b), 16'(vecs[i].e_bad));
    end
`ifdef DEST_REG_SKIP_EN
    skip4 = '0;
`endif

    // Random run over all sizes against a behavioural model.
    ns = '{2, 3, 4, 5, 7, 16};
    for (int j = 0; j < 6; j++) begin
      m_idx[j] = 0; m_wrap[j] = 1'b0; m_bad[j] = 1'b0;
    end
    for (int c = 0; c < 10000; c++) begin
      rst     = (c == 0) || ($urandom_range(0, 99) == 0);
      set     = ($urandom_range(0, 7) == 0);
      ldd     = ($urandom_range(0, 3) != 0);
      dir     = 1'($urandom_range(0, 1));
      set_idx = 5'($urandom_range(0, 31));
      for (int j = 0; j < 6; j++) begin
        int n, wd, sidx;
        n    = ns[j];
        wd   = (n <= 2) ? 1 : $clog2(n);
        sidx = int'(set_idx) % (1 << wd);
        if (rst) begin
          m_idx[j] = n - 1; m_wrap[j] = 1'b0; m_bad[j] = 1'b0;
        end else if (set) begin
          m_wrap[j] = 1'b0;
          if (sidx < n) begin
            m_idx[j] = sidx; m_bad[j] = 1'b0;
          end else begin
            m_bad[j] = 1'b1;
          end
        end else if (ldd) begin
          m_bad[j] = 1'b0;
          if (!dir) begin
            m_wrap[j] = (m_idx[j] == n - 1);
            m_idx[j]  = (m_idx[j] + 1) % n;
          end else begin
            m_wrap[j] = (m_idx[j] == 0);
            m_idx[j]  = (m_idx[j] + n - 1) % n;
          end
        end else begin
          m_wrap[j] = 1'b0; m_bad[j] = 1'b0;
        end
      end
      @(posedge clk); #1;
      for (int j = 0; j < 6; j++) begin
        logic [2:0] inv;
        read_dut(ns[j], s, ix, w, b);
        inv = {$onehot(s), s == (16'h0001 << ix), int'(ix) < ns[j]};
        check($sformatf("rnd%0d_n%0d_idx", c, ns[j]), ix, 16'(m_idx[j]));
        check($sformatf("rnd%0d_n%0d_wrap", c, ns[j]), 16'(w), 16'(m_wrap[j]));
        check($sformatf("rnd%0d_n%0d_bad", c, ns[j]), 16'(b), 16'(m_bad[j]));
        check($sformatf("rnd%0d_n%0d_inv", c, ns[j]), 16'(inv), 16'h0007);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
